// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one synchronous single-port memory
// between instruction fetch (IF), load/store (LS) and display/IO (IO) requesters.
// Ports:
//   clk, reset (sync, active-low)
//   req_*/we_*/addr_*/wdata_*   per-requester request, held until its gnt_*
//   gnt_*                       one-cycle accept pulse (the ISSUE cycle)
//   rvalid_*, rdata             one-cycle read-return strobe, shared read data
//   mem_addr/mem_wdata/mem_we   memory-side request, mem_rdata read return
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_if,
    input  logic              req_ls,
    input  logic              req_io,
    input  logic              we_if,
    input  logic              we_ls,
    input  logic              we_io,
    input  logic [ADDR_W-1:0] addr_if,
    input  logic [ADDR_W-1:0] addr_ls,
    input  logic [ADDR_W-1:0] addr_io,
    input  logic [DATA_W-1:0] wdata_if,
    input  logic [DATA_W-1:0] wdata_ls,
    input  logic [DATA_W-1:0] wdata_io,
    output logic              gnt_if,
    output logic              gnt_ls,
    output logic              gnt_io,
    output logic              rvalid_if,
    output logic              rvalid_ls,
    output logic              rvalid_io,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    localparam logic [1:0] LAT = MEM_LAT[1:0];
    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d, own_q, own_d, cnt_q, cnt_d, c1, c2, win;
    logic [2:0]        req, gnt_q, gnt_d, rv_q, rv_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;

    // Requester index 0=IF, 1=LS, 2=IO; rotation wraps IO back to IF.
    function automatic logic [1:0] nxt(input logic [1:0] p);
        return p == 2'd2 ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        req     = {req_io, req_ls, req_if};
        c1      = nxt(ptr_q);
        c2      = nxt(c1);
        // First requester in rotating order starting at the pointer.
        win     = req[ptr_q] ? ptr_q : req[c1] ? c1 : c2;
        state_d = state_q;
        ptr_d   = ptr_q;
        own_d   = own_q;
        cnt_d   = cnt_q;
        gnt_d   = '0;
        rv_d    = '0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = ISSUE;
                own_d   = win;
                ptr_d   = nxt(win);
                gnt_d   = 3'b001 << win;
                addr_d  = win == 2'd0 ? addr_if  : win == 2'd1 ? addr_ls  : addr_io;
                wdata_d = win == 2'd0 ? wdata_if : win == 2'd1 ? wdata_ls : wdata_io;
                we_d    = win == 2'd0 ? we_if    : win == 2'd1 ? we_ls    : we_io;
            end
            // we_q still holds the owner's write flag during ISSUE.
            ISSUE: begin
                state_d = we_q ? IDLE : WAIT;
                cnt_d   = 2'd1;
            end
            WAIT: if (cnt_q == LAT) begin
                rdata_d = mem_rdata;
                rv_d    = 3'b001 << own_q;
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            own_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            rv_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            own_q   <= own_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            rv_q    <= rv_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign {gnt_io, gnt_ls, gnt_if}          = gnt_q;
    assign {rvalid_io, rvalid_ls, rvalid_if} = rv_q;
    assign rdata     = rdata_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter at MEM_LAT=1 and MEM_LAT=3.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_if, req_ls, req_io, we_if, we_ls, we_io;
    logic [15:0] addr_if, addr_ls, addr_io, wdata_if, wdata_ls, wdata_io;
    logic [2:0]  g1, v1, g3, v3;
    logic [15:0] rd1, ma1, mw1, mr1, rd3, ma3, mw3, mr3, p3a, p3b;
    logic        we1, we3;
    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] ta [3];

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [15:0] a);
        return a == 16'h0040 ? 16'hBEEF : a ^ 16'h5A5A;
    endfunction

    // Memory models: read data appears MEM_LAT cycles after the address cycle.
    always @(posedge clk) begin
        mr1 <= rom(ma1);
        p3a <= rom(ma3);
        p3b <= p3a;
        mr3 <= p3b;
    end

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u1 (
        .clk(clk), .reset(reset),
        .req_if(req_if), .req_ls(req_ls), .req_io(req_io),
        .we_if(we_if), .we_ls(we_ls), .we_io(we_io),
        .addr_if(addr_if), .addr_ls(addr_ls), .addr_io(addr_io),
        .wdata_if(wdata_if), .wdata_ls(wdata_ls), .wdata_io(wdata_io),
        .gnt_if(g1[0]), .gnt_ls(g1[1]), .gnt_io(g1[2]),
        .rvalid_if(v1[0]), .rvalid_ls(v1[1]), .rvalid_io(v1[2]),
        .rdata(rd1), .mem_addr(ma1), .mem_wdata(mw1), .mem_we(we1), .mem_rdata(mr1)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3)) u3 (
        .clk(clk), .reset(reset),
        .req_if(req_if), .req_ls(req_ls), .req_io(req_io),
        .we_if(we_if), .we_ls(we_ls), .we_io(we_io),
        .addr_if(addr_if), .addr_ls(addr_ls), .addr_io(addr_io),
        .wdata_if(wdata_if), .wdata_ls(wdata_ls), .wdata_io(wdata_io),
        .gnt_if(g3[0]), .gnt_ls(g3[1]), .gnt_io(g3[2]),
        .rvalid_if(v3[0]), .rvalid_ls(v3[1]), .rvalid_io(v3[2]),
        .rdata(rd3), .mem_addr(ma3), .mem_wdata(mw3), .mem_we(we3), .mem_rdata(mr3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nx;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        {req_if, req_ls, req_io, we_if, we_ls, we_io} = '0;
        {addr_if, addr_ls, addr_io} = '0;
        {wdata_if, wdata_ls, wdata_io} = '0;
        ta[0] = 16'h0100;
        ta[1] = 16'h0200;
        ta[2] = 16'h0300;
        nx;
        nx;
        chk("rst_gnt", g1, 3'b000);
        chk("rst_rvalid", v1, 3'b000);
        chk("rst_we", we1, 1'b0);
        chk("rst_addr", ma1, 16'h0000);
        chk("rst_rdata", rd1, 16'h0000);
        chk("rst_gnt3", g3, 3'b000);
        reset = 1'b1;
        nx;
        // Single IF read, MEM_LAT=1
        req_if = 1'b1; addr_if = 16'h0040;
        nx;
        chk("if_gnt", g1, 3'b001);
        chk("if_addr", ma1, 16'h0040);
        chk("if_we", we1, 1'b0);
        req_if = 1'b0;
        nx;
        chk("if_wait_gnt", g1, 3'b000);
        chk("if_wait_rvalid", v1, 3'b000);
        nx;
        chk("if_rvalid", v1, 3'b001);
        chk("if_rdata", rd1, 16'hBEEF);
        chk("if_rv_gnt", g1, 3'b000);
        // LS write
        req_ls = 1'b1; we_ls = 1'b1; addr_ls = 16'h1234; wdata_ls = 16'h00FF;
        nx;
        chk("ls_gnt", g1, 3'b010);
        chk("ls_we", we1, 1'b1);
        chk("ls_addr", ma1, 16'h1234);
        chk("ls_wdata", mw1, 16'h00FF);
        chk("ls_rvalid", v1, 3'b000);
        req_ls = 1'b0; we_ls = 1'b0;
        nx;
        chk("ls_we_off", we1, 1'b0);
        chk("ls_no_rvalid", v1, 3'b000);
        chk("ls_gnt_off", g1, 3'b000);
        // Back in IDLE two cycles after a write grant: an IO read is granted next cycle
        req_io = 1'b1; addr_io = 16'h0300;
        nx;
        chk("wr_idle_gnt", g1, 3'b100);
        req_io = 1'b0;
        nx;
        nx;
        chk("io_rvalid", v1, 3'b100);
        chk("io_rdata", rd1, 16'h595A);
        // All three held: pointer now at IF
        addr_if = ta[0]; addr_ls = ta[1]; addr_io = ta[2];
        req_if = 1'b1; req_ls = 1'b1; req_io = 1'b1;
        for (int i = 0; i < 6; i++) begin
            nx;
            chk("rr_gnt", g1, 32'(1) << (i % 3));
            chk("rr_addr", ma1, ta[i % 3]);
            nx;
            chk("rr_wait_gnt", g1, 3'b000);
            nx;
            chk("rr_rvalid", v1, 32'(1) << (i % 3));
            chk("rr_rdata", rd1, rom(ta[i % 3]));
            if (i == 5) begin
                req_if = 1'b0; req_ls = 1'b0; req_io = 1'b0;
            end
        end
        nx;
        chk("rr_drained", g1, 3'b000);
        // Reset during WAIT of an LS read
        req_ls = 1'b1; addr_ls = 16'h0200;
        nx;
        chk("rst_ls_gnt", g1, 3'b010);
        req_ls = 1'b0;
        nx;
        reset = 1'b0;
        nx;
        chk("abort_gnt", g1, 3'b000);
        chk("abort_rvalid", v1, 3'b000);
        chk("abort_we", we1, 1'b0);
        chk("abort_addr", ma1, 16'h0000);
        chk("abort_wdata", mw1, 16'h0000);
        chk("abort_rdata", rd1, 16'h0000);
        reset = 1'b1;
        nx;
        chk("abort_rv1", v1, 3'b000);
        nx;
        chk("abort_rv2", v1, 3'b000);
        // Pointer restarted at IF: LS beats IO
        req_ls = 1'b1; req_io = 1'b1;
        nx;
        chk("ptr_restart", g1, 3'b010);
        req_ls = 1'b0; req_io = 1'b0;
        nx;
        nx;
        chk("restart_rvalid", v1, 3'b010);
        chk("restart_rdata", rd1, 16'h585A);
        // IF request only during ISSUE is never granted
        req_io = 1'b1; addr_io = 16'h0300;
        nx;
        chk("pulse_io_gnt", g1, 3'b100);
        req_io = 1'b0; req_if = 1'b1; addr_if = 16'h0040;
        nx;
        req_if = 1'b0;
        chk("pulse_wait_gnt", g1, 3'b000);
        nx;
        chk("pulse_io_rvalid", v1, 3'b100);
        chk("pulse_io_rdata", rd1, 16'h595A);
        nx;
        chk("pulse_ignored", g1, 3'b000);
        nx;
        chk("pulse_ignored2", g1, 3'b000);
        // MEM_LAT=3 IO read
        reset = 1'b0;
        nx;
        reset = 1'b1;
        req_io = 1'b1; addr_io = 16'h8000;
        nx;
        chk("l3_gnt", g3, 3'b100);
        chk("l3_addr", ma3, 16'h8000);
        req_io = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            nx;
            chk("l3_hold_addr", ma3, 16'h8000);
            chk("l3_no_rvalid", v3, 3'b000);
        end
        nx;
        chk("l3_rvalid", v3, 3'b100);
        chk("l3_rdata", rd3, 16'hDA5A);
        nx;
        chk("l3_rvalid_off", v3, 3'b000);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one synchronous single-port memory between three requesters: instruction fetch (IF), datapath load/store (LS) and a display/IO reader (IO).
- Sits between the CPU top level and the memory block.
- Uses round-robin arbitration with a req/gnt handshake, a one-cycle issue and an `rvalid` return strobe per requester.
- Serves one transaction at a time.

Parameters:
- ADDR_W, 16, address width of all ports.
- DATA_W, 16, data width of all ports.
- MEM_LAT, 1, memory read latency in cycles from address-valid cycle to `mem_rdata` valid; legal range 1..3.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- req_if, req_ls, req_io  in  1 each  request; held high with `we`/`addr`/`wdata` stable until the matching `gnt`.
- we_if, we_ls, we_io  in  1 each  1 = write, 0 = read.
- addr_if, addr_ls, addr_io  in  ADDR_W each  request address.
- wdata_if, wdata_ls, wdata_io  in  DATA_W each  write data.
- gnt_if, gnt_ls, gnt_io  out  1 each  one-cycle pulse: request accepted.
- rvalid_if, rvalid_ls, rvalid_io  out  1 each  one-cycle pulse: `rdata` holds the read result for that requester.
- rdata  out  DATA_W  registered read data, shared; qualified by `rvalid_*`.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data.

Behaviour:
- Reset (`reset`=0 at an edge):
  - state = IDLE; RR pointer = IF.
  - All `gnt_*`, `rvalid_*` and `mem_we` = 0; `mem_addr`, `mem_wdata` and `rdata` = 0.
  - Reset mid-transaction aborts it: no `rvalid` is produced and no `mem_we` pulse follows.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Requests are sampled only here; no request high → stay in IDLE.
  - Winner = first requester with `req` high in rotating order, starting at the pointer (IF→LS→IO→IF).
  - At the edge: `mem_addr`/`mem_wdata`/`mem_we` ← winner's `addr`/`wdata`/`we`; `gnt_winner` ← 1; owner ← winner; pointer ← requester after winner; state ← ISSUE.
- ISSUE (exactly one cycle):
  - `gnt_owner` = 1 and `mem_we` = `we` of owner; `mem_addr`/`mem_wdata` held.
  - At the edge: `gnt` ← 0; `mem_we` ← 0; write → IDLE; read → WAIT with cnt ← 1.
- WAIT:
  - `mem_addr` is held.
  - When cnt == MEM_LAT: `rdata` ← `mem_rdata`, `rvalid_owner` ← 1 for one cycle, state ← IDLE.
  - Otherwise: cnt ← cnt+1.
- Timing with `req` first seen high in IDLE at cycle t:
  - `gnt` and the memory access occur in cycle t+1.
  - Write completes in t+1; next grant earliest t+3.
  - Read: `rvalid` and `rdata` in cycle t+2+MEM_LAT; IDLE arbitrates in that same cycle; next grant earliest t+3+MEM_LAT.
- Invariants:
  - At most one `gnt_*` and one `rvalid_*` high in any cycle.
  - `mem_we` is high only in an ISSUE cycle.
  - `rdata` holds its value between reads.
- A requester dropping `req` before its grant loses the slot silently; no error is flagged.
- Requester tie (several `req` high): the RR order decides; the pointer guarantees each active requester is served within 3 grants.
- `req` arriving during ISSUE/WAIT is ignored until IDLE; it is not latched.

Test Plan:
- Reset then single IF read, MEM_LAT=1: `req_if`=1, addr 0x0040, memory returns 0xBEEF → `gnt_if` in cycle t+1 with `mem_addr`=0x0040, `mem_we`=0; `rvalid_if`=1 and `rdata`=0xBEEF in cycle t+3; no other `gnt`/`rvalid`.
- LS write: `we_ls`=1, addr 0x1234, data 0x00FF → `mem_we`=1 for exactly one cycle (t+1) with `mem_addr`=0x1234 and `mem_wdata`=0x00FF; no `rvalid_ls`; back in IDLE in t+2.
- All three `req` held high continuously, MEM_LAT=1 → grant order IF, LS, IO, IF, LS, IO; reads spaced 3 cycles apart; each requester receives its own `rdata`.
- MEM_LAT=3, IO read of addr 0x8000 → `gnt_io` in t+1; `mem_addr` held at 0x8000 through t+4; `rvalid_io` in t+5.
- `reset`=0 asserted during WAIT of an LS read → the next cycle shows all outputs 0; no `rvalid_ls` ever appears; after release, `req_ls` alone is granted normally and the pointer restarts at IF.
- `req_if` pulsed high during ISSUE only, then dropped → never granted; `req_io` held from IDLE is granted.
